// File: rtl/mem_port_arbiter_if.sv
// Bundle of CPU, DMA and RAM signals around the data-RAM arbiter.
// master = requesters plus RAM side; slave = the arbiter itself.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_stall;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_rvalid;

  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic              dma_gnt;
  logic [DATA_W-1:0] dma_rdata;
  logic              dma_rvalid;

  logic [ADDR_W-1:0] ram_addr;
  logic              ram_read;
  logic              ram_write;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_stall, cpu_rdata, cpu_rvalid,
    output dma_req, dma_we, dma_addr, dma_wdata,
    input  dma_gnt, dma_rdata, dma_rvalid,
    input  ram_addr, ram_read, ram_write, ram_wdata,
    output ram_rdata
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_stall, cpu_rdata, cpu_rvalid,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    output dma_gnt, dma_rdata, dma_rvalid,
    output ram_addr, ram_read, ram_write, ram_wdata,
    input  ram_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// CPU/DMA arbiter for the single-ported data RAM: accept -> RAM pins 1 cycle -> rvalid 2 cycles.
// Losing CPU sees cpu_stall; DMA waits for dma_gnt and is forced through after STARVE_LIMIT contested CPU wins.
module mem_port_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 16,
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic reset_n,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DMA  = 2'd2
  } owner_e;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0]        starve_cnt;
  owner_e            rd_owner;
  owner_e            rsp_owner;
  logic              contested;
  logic              forced_dma;
  logic              cpu_gnt;
  logic              dma_gnt;
  logic [DATA_W-1:0] cpu_rdata_q;
  logic [DATA_W-1:0] dma_rdata_q;

  // Grants are masked by reset_n so nothing is accepted while reset is held.
  always_comb begin
    contested  = bus.cpu_req & bus.dma_req;
    forced_dma = contested & (starve_cnt >= LIMIT);
    cpu_gnt    = reset_n & bus.cpu_req & ~forced_dma;
    dma_gnt    = reset_n & bus.dma_req & (~bus.cpu_req | forced_dma);
  end

  assign bus.cpu_stall = bus.cpu_req & ~cpu_gnt;
  assign bus.dma_gnt   = dma_gnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      starve_cnt    <= 4'd0;
      bus.ram_addr  <= '0;
      bus.ram_wdata <= '0;
      bus.ram_read  <= 1'b0;
      bus.ram_write <= 1'b0;
      rd_owner      <= OWN_NONE;
      rsp_owner     <= OWN_NONE;
      cpu_rdata_q   <= '0;
      dma_rdata_q   <= '0;
    end else begin
      if (dma_gnt) begin
        starve_cnt <= 4'd0;
      end else if (contested && cpu_gnt && starve_cnt < LIMIT) begin
        starve_cnt <= starve_cnt + 4'd1;
      end

      bus.ram_read  <= 1'b0;
      bus.ram_write <= 1'b0;
      rd_owner      <= OWN_NONE;
      if (cpu_gnt) begin
        bus.ram_addr  <= bus.cpu_addr;
        bus.ram_wdata <= bus.cpu_wdata;
        bus.ram_write <= bus.cpu_we;
        bus.ram_read  <= ~bus.cpu_we;
        rd_owner      <= bus.cpu_we ? OWN_NONE : OWN_CPU;
      end else if (dma_gnt) begin
        bus.ram_addr  <= bus.dma_addr;
        bus.ram_wdata <= bus.dma_wdata;
        bus.ram_write <= bus.dma_we;
        bus.ram_read  <= ~bus.dma_we;
        rd_owner      <= bus.dma_we ? OWN_NONE : OWN_DMA;
      end

      // RAM data arrives one cycle after the strobe, so ownership follows one stage behind.
      rsp_owner <= rd_owner;
      if (bus.cpu_rvalid) cpu_rdata_q <= bus.ram_rdata;
      if (bus.dma_rvalid) dma_rdata_q <= bus.ram_rdata;
    end
  end

  assign bus.cpu_rvalid = (rsp_owner == OWN_CPU);
  assign bus.dma_rvalid = (rsp_owner == OWN_DMA);
  assign bus.cpu_rdata  = bus.cpu_rvalid ? bus.ram_rdata : cpu_rdata_q;
  assign bus.dma_rdata  = bus.dma_rvalid ? bus.ram_rdata : dma_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, reset-mid-read sequence and
// randomized traffic scored against a transaction-level model of the arbiter and RAM.
module tb_mem_port_arbiter;

  localparam int LIMIT = 4;

  logic clk;
  logic reset_n;

  mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  mem_port_arbiter #(
    .ADDR_W(16),
    .DATA_W(16),
    .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  function automatic logic [15:0] init_val(input int a);
    if (a == 16'h0010) return 16'hBEEF;
    return 16'(16'h5A00 ^ (a * 16'h0107));
  endfunction

  // RAM behaviour: synchronous write, read data valid the cycle after ram_read.
  logic [15:0] ram_mem [256];
  initial begin
    for (int i = 0; i < 256; i++) ram_mem[i] = init_val(i);
    bus.ram_rdata <= 16'h0000;
    forever begin
      @(posedge clk);
      if (bus.ram_write) ram_mem[bus.ram_addr[7:0]] = bus.ram_wdata;
      if (bus.ram_read) bus.ram_rdata <= ram_mem[bus.ram_addr[7:0]];
    end
  end

  // Reference model state, kept per transaction rather than per flop.
  logic [15:0] ref_mem [256];
  int          m_cnt;
  logic        e_rd, e_wr;
  logic [15:0] e_addr, e_wdata;
  int          r_now_own, r_next_own;
  logic [15:0] r_now_dat, r_next_dat;
  logic [15:0] last_cpu, last_dma;

  task automatic model_reset();
    m_cnt = 0;
    e_rd = 1'b0; e_wr = 1'b0; e_addr = 16'h0; e_wdata = 16'h0;
    r_now_own = 0; r_next_own = 0; r_now_dat = 16'h0; r_next_dat = 16'h0;
    last_cpu = 16'h0; last_dma = 16'h0;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // One clock cycle: drive, check this cycle's outputs, then advance the model.
  task automatic step(input logic cr, input logic cwe, input logic [15:0] ca, input logic [15:0] cd,
                      input logic dr, input logic dwe, input logic [15:0] da, input logic [15:0] dd,
                      output int win);
    logic        w_we;
    logic [15:0] w_addr, w_data;
    @(negedge clk);
    bus.cpu_req = cr; bus.cpu_we = cwe; bus.cpu_addr = ca; bus.cpu_wdata = cd;
    bus.dma_req = dr; bus.dma_we = dwe; bus.dma_addr = da; bus.dma_wdata = dd;
    #1;
    if (cr && dr) win = (m_cnt >= LIMIT) ? 2 : 1;
    else if (cr)  win = 1;
    else if (dr)  win = 2;
    else          win = 0;

    chk("cpu_stall", bus.cpu_stall, cr && win != 1);
    chk("dma_gnt", bus.dma_gnt, win == 2);
    chk("ram_read", bus.ram_read, e_rd);
    chk("ram_write", bus.ram_write, e_wr);
    chk("ram_addr", bus.ram_addr, e_addr);
    chk("ram_wdata", bus.ram_wdata, e_wdata);
    chk("cpu_rvalid", bus.cpu_rvalid, r_now_own == 1);
    chk("dma_rvalid", bus.dma_rvalid, r_now_own == 2);
    chk("cpu_rdata", bus.cpu_rdata, (r_now_own == 1) ? r_now_dat : last_cpu);
    chk("dma_rdata", bus.dma_rdata, (r_now_own == 2) ? r_now_dat : last_dma);
    chk("rvalid_excl", bus.cpu_rvalid & bus.dma_rvalid, 1'b0);

    if (r_now_own == 1) last_cpu = r_now_dat;
    if (r_now_own == 2) last_dma = r_now_dat;
    r_now_own = r_next_own;
    r_now_dat = r_next_dat;
    r_next_own = 0;
    e_rd = 1'b0;
    e_wr = 1'b0;
    if (win != 0) begin
      w_we   = (win == 1) ? cwe : dwe;
      w_addr = (win == 1) ? ca : da;
      w_data = (win == 1) ? cd : dd;
      e_addr = w_addr; e_wdata = w_data; e_wr = w_we; e_rd = ~w_we;
      if (w_we) begin
        ref_mem[w_addr[7:0]] = w_data;
      end else begin
        r_next_own = win;
        r_next_dat = ref_mem[w_addr[7:0]];
      end
    end
    if (win == 2) m_cnt = 0;
    else if (win == 1 && cr && dr) m_cnt++;
  endtask

  typedef struct {
    logic        cr, cwe;
    logic [15:0] ca, cd;
    logic        dr, dwe;
    logic [15:0] da, dd;
    logic        es, eg;
  } vec_t;

  vec_t tbl [26];

  logic        c_pend, c_we, d_pend, d_we;
  logic [15:0] c_addr, c_dat, d_addr, d_dat;

  initial begin
    int w;
    vec_t idle, both;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    idle = '{1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0};
    both = '{1'b1, 1'b0, 16'h0001, 16'h0, 1'b1, 1'b0, 16'h0002, 16'h0, 1'b0, 1'b0};
    tbl[0]  = '{1'b1, 1'b0, 16'h0010, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0};
    tbl[1]  = idle;
    tbl[2]  = idle;
    tbl[3]  = '{1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b1, 16'h0040, 16'h1234, 1'b0, 1'b1};
    tbl[4]  = '{1'b1, 1'b0, 16'h0040, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0};
    tbl[5]  = idle;
    tbl[6]  = idle;
    for (int i = 7; i <= 16; i++) tbl[i] = both;
    tbl[11].es = 1'b1; tbl[11].eg = 1'b1;
    tbl[16].es = 1'b1; tbl[16].eg = 1'b1;
    tbl[17] = '{1'b1, 1'b1, 16'h0050, 16'h5555, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0};
    tbl[18] = '{1'b1, 1'b0, 16'h0001, 16'h0, 1'b1, 1'b0, 16'h0099, 16'h0, 1'b0, 1'b0};
    tbl[19] = '{1'b1, 1'b1, 16'h0051, 16'h6666, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0};
    for (int i = 20; i <= 23; i++) tbl[i] = both;
    tbl[23].es = 1'b1; tbl[23].eg = 1'b1;
    tbl[24] = idle;
    tbl[25] = idle;

    // Reset: outputs cleared, DMA never granted, CPU always stalled.
    reset_n = 1'b0;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0; bus.cpu_wdata = 16'h0;
    bus.dma_req = 1'b0; bus.dma_we = 1'b0; bus.dma_addr = 16'h0; bus.dma_wdata = 16'h0;
    @(negedge clk);
    bus.cpu_req = 1'b1; bus.dma_req = 1'b1;
    #1;
    chk("rst_cpu_stall", bus.cpu_stall, 1'b1);
    chk("rst_dma_gnt", bus.dma_gnt, 1'b0);
    chk("rst_ram_strobes", {bus.ram_read, bus.ram_write}, 2'b00);
    chk("rst_ram_addr", bus.ram_addr, 16'h0);
    chk("rst_ram_wdata", bus.ram_wdata, 16'h0);
    chk("rst_rvalids", {bus.cpu_rvalid, bus.dma_rvalid}, 2'b00);
    chk("rst_rdatas", {bus.cpu_rdata, bus.dma_rdata}, 32'h0);
    @(negedge clk);
    bus.cpu_req = 1'b0; bus.dma_req = 1'b0;
    reset_n = 1'b1;
    model_reset();

    // Directed vectors: single read, write-then-read, starvation, cancelled DMA.
    for (int i = 0; i < 26; i++) begin
      step(tbl[i].cr, tbl[i].cwe, tbl[i].ca, tbl[i].cd,
           tbl[i].dr, tbl[i].dwe, tbl[i].da, tbl[i].dd, w);
      chk($sformatf("tbl%0d_stall", i), bus.cpu_stall, tbl[i].es);
      chk($sformatf("tbl%0d_gnt", i), bus.dma_gnt, tbl[i].eg);
      if (i == 2) chk("beef_read", bus.cpu_rdata, 16'hBEEF);
      if (i == 6) chk("dma_wr_cpu_rd", bus.cpu_rdata, 16'h1234);
    end

    // Reset asserted while a CPU read is on the RAM pins.
    step(1'b1, 1'b0, 16'h0030, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, w);
    @(negedge clk);
    bus.cpu_req = 1'b0;
    #1;
    chk("midrd_ram_read", bus.ram_read, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("midrd_strobes", {bus.ram_read, bus.ram_write}, 2'b00);
    chk("midrd_addr", bus.ram_addr, 16'h0);
    bus.cpu_req = 1'b1; bus.dma_req = 1'b1;
    #1;
    chk("midrd_stall", bus.cpu_stall, 1'b1);
    chk("midrd_gnt", bus.dma_gnt, 1'b0);
    @(negedge clk);
    bus.cpu_req = 1'b0; bus.dma_req = 1'b0;
    reset_n = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, w);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 16'h0003, 16'h0, 1'b1, 1'b0, 16'h0004, 16'h0, w);
      chk($sformatf("post_rst_win%0d", i), w, (i == 4) ? 2 : 1);
    end

    // Random traffic; each port holds its command until accepted or cancelled.
    c_pend = 1'b0; d_pend = 1'b0;
    c_we = 1'b0; d_we = 1'b0; c_addr = 16'h0; d_addr = 16'h0; c_dat = 16'h0; d_dat = 16'h0;
    for (int n = 0; n < 2000; n++) begin
      if (!c_pend && $urandom_range(0, 99) < 60) begin
        c_pend = 1'b1; c_we = 1'($urandom_range(0, 1));
        c_addr = 16'($urandom_range(0, 255)); c_dat = 16'($urandom);
      end else if (c_pend && $urandom_range(0, 99) < 5) begin
        c_pend = 1'b0;
      end
      if (!d_pend && $urandom_range(0, 99) < 60) begin
        d_pend = 1'b1; d_we = 1'($urandom_range(0, 1));
        d_addr = 16'($urandom_range(0, 255)); d_dat = 16'($urandom);
      end else if (d_pend && $urandom_range(0, 99) < 5) begin
        d_pend = 1'b0;
      end
      step(c_pend, c_we, c_addr, c_dat, d_pend, d_we, d_addr, d_dat, w);
      if (w == 1) c_pend = 1'b0;
      if (w == 2) d_pend = 1'b0;
    end
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, w);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter that shares the single-ported data RAM between the pipeline's MEM stage (CPU port) and a loader/DMA port. It grants one access per cycle, registers the winning command onto the RAM pins, and routes returned read data to the owner. It stalls the CPU when it loses arbitration. It sits between the EX/MEM latch outputs and the RAM, and enforces bounded DMA starvation.

## Interface
- ADDR_W, 16, address width of both ports and RAM
- DATA_W, 16, data width of both ports and RAM
- STARVE_LIMIT, 4, contested cycles the CPU may win in a row before DMA is forced through (1..15)

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- cpu_req  in  1  CPU access request (MEM stage ReadMem|WriteMem)
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_stall  out  1  combinational; CPU request not accepted this cycle
- cpu_rdata  out  DATA_W  read data to MEM/WB latch
- cpu_rvalid  out  1  cpu_rdata valid this cycle
- dma_req  in  1  DMA access request
- dma_we  in  1  1 = write, 0 = read
- dma_addr  in  ADDR_W  DMA address
- dma_wdata  in  DATA_W  DMA write data
- dma_gnt  out  1  combinational; DMA request accepted at next edge
- dma_rdata  out  DATA_W  read data to DMA
- dma_rvalid  out  1  dma_rdata valid this cycle
- ram_addr  out  ADDR_W  registered RAM address
- ram_read  out  1  registered RAM read strobe
- ram_write  out  1  registered RAM write strobe
- ram_wdata  out  DATA_W  registered RAM write data
- ram_rdata  in  DATA_W  RAM read data, valid the cycle after ram_read

## Operation
- Grant decision is combinational from the requests and starve_cnt. cpu_gnt and dma_gnt are mutually exclusive.
  - Only one requester active: that requester wins.
  - Both active and starve_cnt < STARVE_LIMIT: CPU wins.
  - Both active and starve_cnt == STARVE_LIMIT: DMA wins.
- cpu_stall = cpu_req & ~cpu_gnt.
- starve_cnt, 4-bit, registered:
  - Increments when both requesters are active and the CPU wins; saturates at STARVE_LIMIT.
  - Clears whenever DMA is granted.
  - Holds otherwise, including a CPU-only cycle.
- On the edge that ends a granted cycle, the winner's command is registered onto the RAM pins:
  - ram_addr ← winner address.
  - ram_wdata ← winner write data.
  - ram_write ← winner we.
  - ram_read ← ~winner we.
- With no grant, ram_read and ram_write go to 0; ram_addr and ram_wdata hold.
- ram_read and ram_write are never both 1.
- Read ownership:
  - A 2-bit rd_owner flop (NONE/CPU/DMA) is loaded on the same edge as ram_read.
  - The following cycle, the owner's rvalid = 1 and its rdata = ram_rdata.
  - The non-owner's rvalid = 0 and its rdata holds its last value.
- Writes produce no rvalid.
- Requester rule: req, we, addr and wdata are held stable until accepted (cpu_stall = 0 / dma_gnt = 1). Dropping req before acceptance cancels the request with no side effects.

## Timing
- Reset (asynchronous assert, synchronous release) forces these to 0:
  - ram_read, ram_write, ram_addr, ram_wdata
  - cpu_rvalid, dma_rvalid, cpu_rdata, dma_rdata
  - starve_cnt, and rd_owner = NONE
- While reset_n = 0: dma_gnt = 0 and cpu_stall = cpu_req.
- Reset mid-read: the pending read is dropped and no rvalid pulses after release.
- Accept-to-RAM latency: 1 cycle. Request accepted in cycle N → RAM command in cycle N+1 → rvalid in cycle N+2.
- Throughput: one access per cycle. Back-to-back reads from either port pipeline with no bubble.
- Alternating owners return data in issue order.

## Test plan
- CPU read only: cpu_req=1, we=0, addr=0x0010 for 1 cycle, RAM[0x10]=0xBEEF. Expect:
  - cpu_stall=0.
  - Next cycle: ram_read=1, ram_addr=0x0010.
  - Following cycle: cpu_rvalid=1, cpu_rdata=0xBEEF; dma_rvalid=0.
- Starvation bound: cpu_req and dma_req both held high, STARVE_LIMIT=4. Expect:
  - Grant pattern CPU,CPU,CPU,CPU,DMA repeating.
  - cpu_stall=1 exactly on every 5th cycle.
  - starve_cnt returns to 0 after each DMA grant.
- DMA write then CPU read of the same address: DMA writes 0x1234 to 0x0040, then CPU reads 0x0040. Expect:
  - ram_write=1 one cycle before ram_read.
  - cpu_rdata=0x1234 with cpu_rvalid=1.
  - dma_rvalid never asserted.
- Interleaved reads: CPU reads 0x0001 while DMA reads 0x0002, with DMA forced by the starve limit. Expect:
  - rvalid pulses in issue order, each carrying the correct RAM word.
  - No cycle with both rvalids high.
- Reset mid-operation: assert reset_n=0 in the cycle ram_read=1 for a CPU read. Expect:
  - All RAM strobes 0 immediately.
  - No cpu_rvalid after release.
  - starve_cnt=0.
  - First post-reset request granted normally.
- Cancelled request: dma_req pulses for 1 cycle while the CPU wins with starve_cnt < limit. Expect:
  - No DMA access ever reaches the RAM pins.
  - starve_cnt incremented by 1.
